// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// It sends one command byte to a PS/2 device. The sequence is: clock inhibit, then
// request-to-send, then an 11-bit frame clocked by the device, then an ACK check.
// Both lines are open-drain. This block only ever pulls them low through the *_oe
// outputs.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   tx_data[7:0]          byte to send, captured when tx_start is accepted
//   tx_start              start request, honoured only while ready=1
//   ready                 idle with both lines released
//   done / error          one-cycle completion pulses (ACK / timeout or NAK)
//   ps2_clk_i, ps2_dat_i  raw line levels
//   ps2_clk_oe, ps2_dat_oe  1 = pull the line low

// Per-line input conditioner: a 2-FF synchronizer followed by a FILT-sample
// debounce. The output level changes only after FILT consecutive synchronized
// samples that differ from the current level.
module ps2_in_filt #(
  parameter int unsigned FILT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic lvl_o
);
  localparam int unsigned CW = (FILT > 1) ? $clog2(FILT) : 1;

  logic          s1_q, s2_q, lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CW'(FILT - 1)) lvl_d = s2_q;
      else                        cnt_d = cnt_q + 1'b1;
    end
  end

  // Idle lines are high, so every stage resets to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      lvl_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign lvl_o = lvl_q;
endmodule

module ps2_host_tx #(
  parameter int unsigned CLK_HZ = 24_000_000,
  parameter int unsigned FILT   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       ready,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);
  localparam logic [31:0] INH_CYC  = 32'(CLK_HZ / 10_000);
  localparam logic [31:0] REQ_CYC  = 32'(CLK_HZ / 200_000);
  localparam logic [31:0] START_TO = 32'((64'(CLK_HZ) * 15) / 1000);
  localparam logic [31:0] FRAME_TO = 32'((64'(CLK_HZ) * 2) / 1000);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, WAIT_IDLE} state_t;

  state_t      state_q, state_d;
  logic [31:0] tmr_q, tmr_d;
  logic [3:0]  n_q, n_d, n_nx;
  logic [9:0]  sh_q, sh_d;     // {stop, parity, data} shifted out LSB first
  logic        drv_q, drv_d;   // 1 = hold data low during SEND
  logic        nak_q, nak_d;
  logic        clk_prev_q;
  logic        clk_lvl, dat_lvl, fe;

  ps2_in_filt #(.FILT(FILT)) u_clk_filt (.clk(clk), .rst(rst), .raw_i(ps2_clk_i), .lvl_o(clk_lvl));
  ps2_in_filt #(.FILT(FILT)) u_dat_filt (.clk(clk), .rst(rst), .raw_i(ps2_dat_i), .lvl_o(dat_lvl));

  assign fe   = clk_prev_q & ~clk_lvl;
  assign n_nx = n_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q + 32'd1;
    n_d        = n_q;
    sh_d       = sh_q;
    drv_d      = drv_q;
    nak_d      = nak_q;
    ready      = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        tmr_d = '0;
        if (tx_start) begin
          sh_d    = {1'b1, ~^tx_data, tx_data};
          nak_d   = 1'b0;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (tmr_q == INH_CYC - 32'd1) begin
          tmr_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        ps2_clk_oe = 1'b1;
        ps2_dat_oe = 1'b1;
        if (tmr_q == REQ_CYC - 32'd1) begin
          tmr_d   = '0;
          n_d     = '0;
          drv_d   = 1'b1;          // keep the start bit on the line
          state_d = SEND;
        end
      end
      SEND: begin
        ps2_dat_oe = drv_q;
        // Before fe 1 the timer measures the start wait; after it, the frame.
        if ((n_q == 4'd0 && tmr_q == START_TO) || (n_q != 4'd0 && tmr_q == FRAME_TO)) begin
          ps2_dat_oe = 1'b0;
          error      = 1'b1;
          drv_d      = 1'b0;
          state_d    = IDLE;
        end else if (fe) begin
          n_d = n_nx;
          if (n_nx == 4'd1) tmr_d = '0;
          if (n_nx == 4'd11) begin
            nak_d   = dat_lvl;
            drv_d   = 1'b0;
            tmr_d   = '0;
            state_d = WAIT_IDLE;
          end else begin
            drv_d = ~sh_q[0];
            sh_d  = {1'b1, sh_q[9:1]};
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_lvl && dat_lvl) begin
          done    = ~nak_q;
          error   = nak_q;
          state_d = IDLE;
        end else if (tmr_q == FRAME_TO) begin
          error   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      n_q        <= '0;
      sh_q       <= '0;
      drv_q      <= 1'b0;
      nak_q      <= 1'b0;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      n_q        <= n_d;
      sh_q       <= sh_d;
      drv_q      <= drv_d;
      nak_q      <= nak_d;
      clk_prev_q <= clk_lvl;
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ready, done, error, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk = 1'b1, dev_dat = 1'b1;
  logic       ps2_clk_i, ps2_dat_i;
  int         n_cmp = 0, n_bad = 0;
  int         done_cnt = 0, err_cnt = 0;
  logic       pulse_prev = 1'b0;
  logic [10:0] cap;

  // Wired-AND of the open-drain bus
  assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(.CLK_HZ(1_000_000), .FILT(4)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
    .ready(ready), .done(done), .error(error),
    .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference frame: start 0, data LSB first, odd parity, stop 1 (index 0 = start)
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (done | error) chk("excl", 32'(done & error), 32'd0);
    if (pulse_prev) begin
      chk("rdy_after", 32'(ready), 32'd1);
      chk("one_cyc", 32'(done | error), 32'd0);
    end
    pulse_prev <= done | error;
  end

  // Device: waits for request-to-send, then clocks 11 bits with a period of 80 cycles.
  // It samples data just before each rising edge.
  task automatic dev_frame(input bit ack, input int glitch_k, input int start_k, input int rst_k,
                           input logic [7:0] d, output logic [10:0] c, output bit ok, output bit aborted);
    int w = 0;
    c = '0; ok = 1'b0; aborted = 1'b0;
    while (!(ps2_dat_oe && !ps2_clk_oe) && w < 400) begin tick(1); w++; end
    if (w >= 400) return;
    ok = 1'b1;
    tick(10);
    c[0] = ps2_dat_i;
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      if (k == rst_k) begin
        tick(10); rst = 1'b1; dev_clk = 1'b1; tick(1); rst = 1'b0;
        aborted = 1'b1;
        return;
      end
      if (k == start_k) begin
        tick(5); tx_data = ~d; tx_start = 1'b1; tick(1); tx_start = 1'b0; tick(34);
      end else tick(40);
      if (k <= 10) c[k] = ps2_dat_i;
      dev_clk = 1'b1;
      if (k == 10 && ack) begin tick(20); dev_dat = 1'b0; tick(20); end
      else if (k == glitch_k) begin tick(15); dev_clk = 1'b0; tick(2); dev_clk = 1'b1; tick(23); end
      else if (k < 11) tick(40);
    end
    dev_dat = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] d, input bit ack, input int glitch_k, input int start_k,
                           input int rst_k, input string tag, output logic [10:0] c);
    bit ok, ab;
    int d0, e0, w;
    d0 = done_cnt; e0 = err_cnt; w = 0;
    tx_data = d; tx_start = 1'b1; tick(1); tx_start = 1'b0;
    chk({tag, "_rdy0"}, 32'(ready), 32'd0);
    dev_frame(ack, glitch_k, start_k, rst_k, d, c, ok, ab);
    chk({tag, "_req"}, 32'(ok), 32'd1);
    if (ab) begin
      chk({tag, "_rst_rdy"}, 32'(ready), 32'd1);
      chk({tag, "_rst_oe"}, {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    end else begin
      chk({tag, "_frame"}, 32'(c), 32'(model_frame(d)));
      while (done_cnt == d0 && err_cnt == e0 && w < 400) begin tick(1); w++; end
      tick(2);
      chk({tag, "_done"}, 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
      chk({tag, "_err"}, 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
      chk({tag, "_idle"}, {29'd0, ready, ps2_clk_oe, ps2_dat_oe}, 32'd4);
    end
    tick(20);
  endtask

  initial begin
    int c, d0;
    tick(3);
    chk("rst_state", {28'd0, ready, done, error, ps2_clk_oe | ps2_dat_oe}, 32'd8);
    rst = 1'b0;
    tick(5);

    run_frame(8'hED, 1'b1, 0, 0, 0, "ed", cap);
    run_frame(8'h00, 1'b1, 0, 0, 0, "x00", cap);
    chk("par00", 32'(cap[9]), 32'd1);
    run_frame(8'h07, 1'b1, 0, 0, 0, "x07", cap);
    chk("par07", 32'(cap[9]), 32'd0);

    // Silent device: start timeout and the request timing along the way
    d0 = done_cnt;
    tx_data = 8'h5A; tx_start = 1'b1; tick(1); tx_start = 1'b0;
    chk("c1", {30'd0, ready, ps2_clk_oe}, 32'd1);
    tick(99);
    chk("c100_dat", 32'(ps2_dat_oe), 32'd0);
    tick(1);
    chk("c101", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd3);
    tick(5);
    chk("c106", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd1);
    c = 106;
    while (!error && c < 15300) begin tick(1); c++; end
    chk("to_cyc", 32'(c), 32'd15106);
    chk("to_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    tick(5);
    chk("to_nodone", 32'(done_cnt - d0), 32'd0);
    tick(20);

    run_frame(8'($urandom), 1'b0, 0, 0, 0, "nak", cap);
    run_frame(8'hA6, 1'b1, 0, 3, 0, "ign", cap);
    run_frame(8'h3C, 1'b1, 0, 0, 5, "rst", cap);
    run_frame(8'h55, 1'b1, 0, 0, 0, "r55", cap);
    run_frame(8'h9B, 1'b1, 4, 0, 0, "glt", cap);
    for (int i = 0; i < 5; i++) begin
      run_frame(8'($urandom), 1'b1, 0, 0, 0, "rnd", cap);
      tick(int'($urandom_range(1, 50)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED followed by an LED mask so the keyboard LEDs track the decoder's caps_lock state. It drives the open-drain PS/2 clock and data lines through output-enable pins and runs the full sequence: inhibit, request-to-send, 11-bit frame clocked by the device, then ACK check. It sits beside the PS/2 receiver/decoder on the same two pins. The receiver must ignore line activity while `ready` is 0.

## Interface
- CLK_HZ, 24_000_000, system clock frequency. Derived constants:
  - INH_CYC = CLK_HZ/10_000 (100 µs)
  - REQ_CYC = CLK_HZ/200_000 (5 µs)
  - START_TO = CLK_HZ*15/1000 (15 ms)
  - FRAME_TO = CLK_HZ*2/1000 (2 ms)
- FILT, 4, consecutive identical synchronized samples needed to accept a new line level.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tx_data  in  8  byte to send; sampled when the start is accepted
- tx_start  in  1  start request; accepted only when ready=1
- ready  out  1  idle, lines released
- done  out  1  one-cycle pulse: frame ACKed and both lines back high
- error  out  1  one-cycle pulse: timeout or NAK
- ps2_clk_i  in  1  raw PS/2 clock line
- ps2_dat_i  in  1  raw PS/2 data line
- ps2_clk_oe  out  1  1 = pull clock low
- ps2_dat_oe  out  1  1 = pull data low

## Operation
- Input conditioning:
  - Each input passes through a 2-FF synchronizer, then a FILT-sample filter.
  - A falling edge ("fe") is the filtered clock level going 1→0.
- Reset values: ready=1, done=0, error=0, ps2_clk_oe=0, ps2_dat_oe=0, state IDLE. A reset mid-frame releases both lines at the reset edge.
- States:
  - IDLE: ready=1. tx_start=1 latches tx_data and computes odd parity p = ~^tx_data; go to INHIBIT.
  - INHIBIT: clk_oe=1, dat_oe=0 for INH_CYC cycles; then go to REQ.
  - REQ: clk_oe=1, dat_oe=1 (start bit 0) for REQ_CYC cycles; then go to SEND.
  - SEND: clk_oe=0. The bit counter n starts at 0 and advances on each fe. Start timer = START_TO.
    - fe 1..8: drive data bit n-1 (LSB first); dat_oe = ~bit.
    - fe 9: drive parity p.
    - fe 10: dat_oe=0 (stop bit 1).
    - fe 11: sample filtered data. 0 = ACK, go to WAIT_IDLE. 1 = NAK, go to WAIT_IDLE with the NAK flag set.
    - Frame timer starts at fe 1 and is loaded with FRAME_TO.
  - WAIT_IDLE: lines released. When filtered clock and data are both 1: pulse done (ACK) or error (NAK), then go to IDLE.
- Timeouts:
  - No fe 1 within START_TO cycles of entering SEND: error.
  - fe 11 not reached within FRAME_TO cycles of fe 1: error.
  - On either timeout: release both lines and pulse error; go directly to IDLE.
  - The WAIT_IDLE check is also bounded by FRAME_TO; on expiry, pulse error.
- tx_start while ready=0 is ignored. done and error are never asserted together.
- Counters are 32-bit unsigned, so no overflow for CLK_HZ ≤ 200 MHz.

## Timing
- Cycle 0: tx_start=1 with ready=1.
- Cycle 1: ready=0, clk_oe=1.
- Cycle INH_CYC+1: dat_oe=1.
- Cycle INH_CYC+REQ_CYC+1: clk_oe=0, SEND begins.
- Data output changes on the cycle after fe is detected. Detection latency is 2+FILT cycles after the raw line falls.
- The device samples data on the rising clock edge. The data setup time therefore equals the device's clock-low time minus (3+FILT) cycles.
- done/error: exactly one cycle. ready returns to 1 on the cycle after the pulse.

## Test plan
Bench uses CLK_HZ=1_000_000 (INH_CYC=100, REQ_CYC=5, START_TO=15000, FRAME_TO=2000), FILT=4, and a device model clocking with an 80-cycle period.

- Send 0xED with the device ACKing -> device captures start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Then one done pulse, no error, ready=1, both OEs 0.
- Send 0x00, then 0x07 -> parity bits 1 and 0 respectively; each frame ends with done.
- No device clock after REQ -> error pulse at cycle 106+15000 (±1). Both OEs 0 from that cycle; no done.
- Device holds data high at fe 11 (NAK) -> error pulse once lines idle; done stays 0.
- tx_start pulsed during SEND is ignored and the frame is unchanged. Reset asserted at fe 5 -> next cycle both OEs 0, ready=1; a subsequent tx_start of 0x55 sends correctly.
- A 2-cycle low glitch on ps2_clk_i during SEND -> no bit advance; the device captures the correct byte.
